// File: rtl/mux_channel_scanner.sv
// rtl/mux_channel_scanner.sv - drives 4:1 mux selects and collects the four channels into one word per frame.
// Optional SCAN_CONTINUOUS_EN: back-to-back frames while start stays high at frame end.
module mux_channel_scanner #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  output logic       s1,
  output logic       s0,
  output logic [3:0] data,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    SAMPLE = 2'b10
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       changed_q, changed_d;
  logic       busy_q, busy_d;
  logic       first_q, first_d;
  logic [3:0] new_word;

  assign new_word = {mux_out, shadow_q};

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    busy_d    = busy_q;
    first_d   = first_q;
    case (state_q)
      IDLE: begin
        sel_d  = 2'b00;
        busy_d = 1'b0;
        if (start) begin
          state_d = SETTLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        case (sel_q)
          2'b00:   shadow_d[0] = mux_out;
          2'b01:   shadow_d[1] = mux_out;
          2'b10:   shadow_d[2] = mux_out;
          default: shadow_d    = shadow_q;
        endcase
        cnt_d = 4'd0;
        if (sel_q != 2'b11) begin
          sel_d   = sel_q + 2'd1;
          state_d = SETTLE;
        end else begin
          // last channel goes straight to data; the shadow only holds channels 0..2
          data_d    = new_word;
          valid_d   = 1'b1;
          changed_d = first_q | (new_word != data_q);
          first_d   = 1'b0;
          sel_d     = 2'b00;
`ifdef SCAN_CONTINUOUS_EN
          if (start) begin
            state_d = SETTLE;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'b00;
      cnt_q     <= 4'd0;
      shadow_q  <= 3'b000;
      data_q    <= 4'b0000;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
      first_q   <= first_d;
    end
  end

  assign s1      = sel_q[1];
  assign s0      = sel_q[0];
  assign data    = data_q;
  assign valid   = valid_q;
  assign changed = changed_q;
  assign busy    = busy_q;

endmodule

// File: doc/mux_channel_scanner.md
Name: mux_channel_scanner

Overview:
- Sequencer that sits directly upstream of the 4:1 single-bit mux and drives its select lines `s1`/`s0`.
- It also captures the mux output `out`, so one frame collects all four channels into a parallel 4-bit word.
- Between select changes it waits a programmable number of settle cycles.
- At the end of each frame it reports whether the word differs from the previous frame.

Parameters:
- SETTLE_CYCLES, 2, cycles the select is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  frame request; level-sampled in IDLE only.
- mux_out  input  1  connects to the mux `out`.
- s1  output  1  mux select MSB.
- s0  output  1  mux select LSB.
- data  output  4  last completed frame; data[k] = channel k (k = {s1,s0}).
- valid  output  1  one-cycle pulse: data was updated this cycle.
- changed  output  1  qualified by valid: new frame differs from the previous frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Clock and reset:
  - One clock.
  - rst_n is asynchronous, active-low, and takes effect immediately.
  - Reset forces state=IDLE, sel=00, settle count=0, data=0000, valid=0, changed=0, busy=0, first_frame=1.
- Output timing:
  - s1/s0 are the registered sel bits.
  - All outputs are registered; none is combinational from inputs.
- IDLE:
  - busy=0, sel=00.
  - start=1 sampled at edge N → SETTLE, sel=00, count=0, busy=1.
- SETTLE:
  - count increments every edge.
  - When count==SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE:
  - On the exit edge, mux_out is written to shadow[sel]; the select has then been stable SETTLE_CYCLES+1 cycles.
  - If sel≠11: sel←sel+1, count←0, → SETTLE.
  - If sel==11 (frame end):
    - data←{mux_out, shadow[2:0]}.
    - valid←1.
    - changed←first_frame OR (new word ≠ data).
    - first_frame←0, sel←00, busy←0, → IDLE (or see optional feature).
- Latency: valid is high for exactly one cycle, starting 4×(SETTLE_CYCLES+1) edges after edge N (12 edges for the default).
- valid/changed deassert on the next edge.
- data holds its value until the next frame completes.
- start asserted while busy=1 is ignored; it is not queued.
- Boundary conditions:
  - SETTLE_CYCLES=1: SETTLE lasts one cycle; frame = 8 edges.
  - Reset asserted mid-frame: abort; partial shadow is discarded; data returns to 0000; no valid pulse.
  - First frame after reset always reports changed=1.
  - mux_out is sampled only in SAMPLE; changes during SETTLE have no effect.

Optional Feature:
- Macro: SCAN_CONTINUOUS_EN.
- Defined: at frame end, if start=1 on that same edge, the FSM enters SETTLE with sel=00 directly.
  - busy stays 1.
  - Frames run back-to-back with period 4×(SETTLE_CYCLES+1) edges.
  - valid pulses once per frame.
  - Deasserting start lets the current frame finish, then the FSM goes to IDLE.
- Undefined: the FSM always returns to IDLE after a frame.
  - A new frame needs start sampled in IDLE, so there is at least one IDLE cycle between frames.

Test Plan:
- Basic frame: reset, channels i0..i3 = 1,0,1,1, pulse start one cycle.
  - Required: s1s0 steps 00→01→10→11, each held 3 cycles.
  - valid for one cycle 12 edges after start.
  - data=4'b1101, changed=1, busy falls with valid.
- Repeat identical frame: same channels, start again → data=4'b1101, changed=0. Then set i2=0 and start → data=4'b1001, changed=1.
- Settle-window isolation: toggle i1 only while s1s0=01 is in SETTLE, holding i1=1 at the sample edge → data[1]=1.
  - Repeat with i1=0 at the sample edge → data[1]=0.
- Start while busy: pulse start again 5 cycles into a frame → exactly one valid pulse; next frame begins only after IDLE is revisited.
- Reset mid-frame: assert rst_n=0 while s1s0=10.
  - Required: immediately s1s0=00, busy=0, data=0000, no valid pulse.
  - After release, the first frame reports changed=1.
- SCAN_CONTINUOUS_EN, SETTLE_CYCLES=1: hold start high for 3 frames → valid pulses every 8 edges, busy continuously 1; drop start → FSM ends in IDLE after the current frame.
